// File: rtl/reg_file_8x16.sv
// Parameterised register file with one shared address port and a registered read.
// Define REGFILE8X16_RDVALID_EN to add the RdValid strobe output.
module reg_file_8x16 #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  WrData,
  input  logic [ADDR_W-1:0] Address,
  input  logic              WrEn,
  input  logic              RdEn,
`ifdef REGFILE8X16_RDVALID_EN
  output logic              RdValid,
`endif
  output logic [WIDTH-1:0]  RdData
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_VAL = DEPTH[ADDR_W:0];

  logic [WIDTH-1:0] regs [DEPTH];
  logic [IDX_W-1:0] regIdx;
  logic             inRange;
  logic             doWrite;
  logic             doRead;

  // Simultaneous read and write requests cancel each other out.
  always_comb begin
    regIdx  = Address[IDX_W-1:0];
    inRange = ({1'b0, Address} < DEPTH_VAL);
    doWrite = WrEn && !RdEn && inRange;
    doRead  = RdEn && !WrEn;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (doWrite) begin
      regs[regIdx] <= WrData;
    end
  end

  // Out-of-range reads are still accepted; they return zero.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RdData <= '0;
    end else if (doRead) begin
      RdData <= inRange ? regs[regIdx] : '0;
    end
  end

`ifdef REGFILE8X16_RDVALID_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RdValid <= 1'b0;
    end else begin
      RdValid <= doRead;
    end
  end
`endif

endmodule

// File: tb/tb_reg_file_8x16.sv
// Self-checking bench for reg_file_8x16 against an array-based reference model.
// Honours REGFILE8X16_RDVALID_EN the same way as the design.
module tb_reg_file_8x16;

  logic        CLK;
  logic        RST;
  logic [15:0] WrData;
  logic [3:0]  Address;
  logic        WrEn;
  logic        RdEn;
  logic [15:0] RdData;
`ifdef REGFILE8X16_RDVALID_EN
  logic        RdValid;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] model [8];
  logic [15:0] expRd;
  logic        expValid;

  reg_file_8x16 #(.WIDTH(16), .DEPTH(8), .ADDR_W(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .WrData  (WrData),
    .Address (Address),
    .WrEn    (WrEn),
    .RdEn    (RdEn),
`ifdef REGFILE8X16_RDVALID_EN
    .RdValid (RdValid),
`endif
    .RdData  (RdData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic modelReset();
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    expRd    = 16'h0;
    expValid = 1'b0;
  endtask

  // Drive one request on the falling edge, let the rising edge take it, update the model.
  task automatic doCycle(input logic we, input logic re, input logic [3:0] addr,
                         input logic [15:0] data);
    @(negedge CLK);
    WrEn = we; RdEn = re; Address = addr; WrData = data;
    @(posedge CLK);
    expValid = 1'b0;
    if (we && !re && addr < 4'd8) model[addr[2:0]] = data;
    if (re && !we) begin
      expRd    = (addr < 4'd8) ? model[addr[2:0]] : 16'h0;
      expValid = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; WrEn = 1'b0; RdEn = 1'b0; Address = 4'd0; WrData = 16'h0;
    modelReset();
    #1;
    vectors++;
    if (RdData !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_rddata: got %h want 0000", RdData);
    end
`ifdef REGFILE8X16_RDVALID_EN
    vectors++;
    if (RdValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_rdvalid: got %b want 0", RdValid);
    end
`endif
    @(negedge CLK); @(negedge CLK);
    RST = 1'b1;
    for (int a = 0; a < 8; a++) begin
      doCycle(1'b0, 1'b1, a[3:0], 16'hFFFF);
      vectors++;
      if (RdData !== 16'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_read%0d: got %h want 0000", a, RdData);
      end
    end
  endtask

  task automatic test_write_read();
    doCycle(1'b1, 1'b0, 4'd6, 16'd15);
    vectors++;
    if (RdData !== expRd) begin
      miscompares++;
      $display("[TB] FAIL write_holds_rddata: got %h want %h", RdData, expRd);
    end
    doCycle(1'b0, 1'b1, 4'd6, 16'd5);
    vectors++;
    if (RdData !== 16'd15) begin
      miscompares++;
      $display("[TB] FAIL read_after_write: got %h want 000f", RdData);
    end
`ifdef REGFILE8X16_RDVALID_EN
    vectors++;
    if (RdValid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rdvalid_pulse: got %b want 1", RdValid);
    end
    doCycle(1'b0, 1'b0, 4'd6, 16'd0);
    vectors++;
    if (RdValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rdvalid_drop: got %b want 0", RdValid);
    end
`endif
  endtask

  task automatic test_collision();
    doCycle(1'b1, 1'b1, 4'd6, 16'd5);
    vectors++;
    if (RdData !== 16'd15) begin
      miscompares++;
      $display("[TB] FAIL collision_hold: got %h want 000f", RdData);
    end
`ifdef REGFILE8X16_RDVALID_EN
    vectors++;
    if (RdValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL collision_rdvalid: got %b want 0", RdValid);
    end
`endif
    doCycle(1'b0, 1'b0, 4'd0, 16'd0);
    doCycle(1'b0, 1'b1, 4'd6, 16'd0);
    vectors++;
    if (RdData !== 16'd15) begin
      miscompares++;
      $display("[TB] FAIL collision_no_write: got %h want 000f", RdData);
    end
  endtask

  task automatic test_out_of_range();
    for (int a = 0; a < 8; a++) doCycle(1'b1, 1'b0, a[3:0], 16'h1000 + 16'(a));
    doCycle(1'b1, 1'b0, 4'd9, 16'hABCD);
    doCycle(1'b0, 1'b1, 4'd9, 16'h0);
    vectors++;
    if (RdData !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL oor_read: got %h want 0000", RdData);
    end
    for (int a = 1; a < 8; a++) begin
      doCycle(1'b0, 1'b1, a[3:0], 16'h0);
      vectors++;
      if (RdData !== 16'h1000 + 16'(a)) begin
        miscompares++;
        $display("[TB] FAIL oor_unchanged%0d: got %h want %h", a, RdData, 16'h1000 + 16'(a));
      end
    end
  endtask

  task automatic test_reset_mid();
    doCycle(1'b0, 1'b1, 4'd6, 16'h0);
    @(negedge CLK);
    WrEn = 1'b1; RdEn = 1'b0; Address = 4'd3; WrData = 16'h1234;
    #2;
    RST = 1'b0;
    modelReset();
    #1;
    vectors++;
    if (RdData !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got %h want 0000", RdData);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    WrEn = 1'b0;
    RST = 1'b1;
    doCycle(1'b0, 1'b1, 4'd3, 16'h0);
    vectors++;
    if (RdData !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_abort_write: got %h want 0000", RdData);
    end
    doCycle(1'b0, 1'b1, 4'd6, 16'h0);
    vectors++;
    if (RdData !== 16'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_cleared6: got %h want 0000", RdData);
    end
  endtask

  task automatic test_first_after_reset();
    @(negedge CLK);
    RST = 1'b0;
    modelReset();
    @(negedge CLK);
    RST = 1'b1;
    doCycle(1'b1, 1'b0, 4'd2, 16'hBEEF);
    doCycle(1'b0, 1'b1, 4'd2, 16'h0);
    vectors++;
    if (RdData !== 16'hBEEF) begin
      miscompares++;
      $display("[TB] FAIL first_op_after_reset: got %h want beef", RdData);
    end
  endtask

  task automatic test_random();
    logic we, re;
    logic [3:0] addr;
    logic [15:0] data;
    for (int n = 0; n < 300; n++) begin
      we   = ($urandom_range(0, 99) < 45);
      re   = ($urandom_range(0, 99) < 45);
      addr = 4'($urandom_range(0, 11));
      data = 16'($urandom);
      doCycle(we, re, addr, data);
      vectors++;
      if (RdData !== expRd) begin
        miscompares++;
        $display("[TB] FAIL random%0d: we=%b re=%b a=%0d got %h want %h",
                 n, we, re, addr, RdData, expRd);
      end
`ifdef REGFILE8X16_RDVALID_EN
      vectors++;
      if (RdValid !== expValid) begin
        miscompares++;
        $display("[TB] FAIL random_valid%0d: got %b want %b", n, RdValid, expValid);
      end
`endif
    end
  endtask

  initial begin
    $display("[TB] starting reg_file_8x16 bench");
    test_reset();
    test_write_read();
    test_collision();
    test_out_of_range();
    test_reset_mid();
    test_first_after_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
